// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command decoder.
package uart_cmd_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 10_000_000;

   localparam logic [7:0] CH_R  = 8'h52;
   localparam logic [7:0] CH_C  = 8'h43;
   localparam logic [7:0] CH_M  = 8'h4D;
   localparam logic [7:0] CH_U  = 8'h55;
   localparam logic [7:0] CH_D  = 8'h44;
   localparam logic [7:0] CH_S  = 8'h53;
   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;
   localparam logic [7:0] CH_LA = 8'h61;
   localparam logic [7:0] CH_LZ = 8'h7A;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DIG0,
      ST_DIG1,
      ST_DIG2,
      ST_DIG3,
      ST_DIG4,
      ST_DIG5,
      ST_TERM
   } state_t;

endpackage

// File: rtl/ascii_time_field.sv
// Two decimal digits -> binary value plus range flag against MAX.
module ascii_time_field
   import uart_cmd_pkg::*;
#(
   parameter int unsigned MAX = 59,
   parameter int unsigned W   = 6
) (
   input  logic [3:0]   tens,
   input  logic [3:0]   ones,
   output logic [W-1:0] value,
   output logic         in_range
);

   logic [6:0] tens7;
   logic [6:0] sum7;

   // 7-bit intermediate so an out-of-range pair such as 99 cannot wrap into range
   assign tens7    = {3'b000, tens};
   assign sum7     = (tens7 << 3) + (tens7 << 1) + {3'b000, ones};
   assign value    = sum7[W-1:0];
   assign in_range = (sum7 <= 7'(MAX));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Pops RX FIFO bytes, decodes single-letter commands into pulses and parses T frames.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] rx_fifo_data,
   output logic       pop,
   output logic       o_run_stop,
   output logic       o_clear,
   output logic       o_mode,
   output logic       o_up,
   output logic       o_down,
   output logic       o_sensor_req,
   output logic       o_set_valid,
   output logic [4:0] o_set_hour,
   output logic [5:0] o_set_min,
   output logic [5:0] o_set_sec,
   output logic       o_cmd_err
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [3:0]    dig [0:5];
   logic [2:0]    dig_idx;
   logic [7:0]    byte_uc;
   logic          is_digit;
   logic          is_eol;
   logic          tmo;
   logic [4:0]    hour_val;
   logic [5:0]    min_val;
   logic [5:0]    sec_val;
   logic          hour_ok;
   logic          min_ok;
   logic          sec_ok;

   assign pop      = ~rx_empty;
   assign byte_uc  = (rx_fifo_data >= CH_LA && rx_fifo_data <= CH_LZ) ?
                     (rx_fifo_data & 8'hDF) : rx_fifo_data;
   assign is_digit = (rx_fifo_data >= CH_0) && (rx_fifo_data <= CH_9);
   assign is_eol   = (rx_fifo_data == CH_CR) || (rx_fifo_data == CH_LF);
   assign tmo      = (cnt == CW'(TIMEOUT_CYCLES - 1));

   ascii_time_field #(.MAX(23), .W(5)) u_hour (
      .tens(dig[0]), .ones(dig[1]), .value(hour_val), .in_range(hour_ok)
   );
   ascii_time_field #(.MAX(59), .W(6)) u_min (
      .tens(dig[2]), .ones(dig[3]), .value(min_val), .in_range(min_ok)
   );
   ascii_time_field #(.MAX(59), .W(6)) u_sec (
      .tens(dig[4]), .ones(dig[5]), .value(sec_val), .in_range(sec_ok)
   );

   always_comb begin
      dig_idx   = '0;
      state_nxt = ST_IDLE;
      unique case (state)
         ST_DIG0: begin dig_idx = 3'd0; state_nxt = ST_DIG1; end
         ST_DIG1: begin dig_idx = 3'd1; state_nxt = ST_DIG2; end
         ST_DIG2: begin dig_idx = 3'd2; state_nxt = ST_DIG3; end
         ST_DIG3: begin dig_idx = 3'd3; state_nxt = ST_DIG4; end
         ST_DIG4: begin dig_idx = 3'd4; state_nxt = ST_DIG5; end
         ST_DIG5: begin dig_idx = 3'd5; state_nxt = ST_TERM; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         for (int unsigned i = 0; i < 6; i++) dig[i] <= '0;
         o_run_stop   <= 1'b0;
         o_clear      <= 1'b0;
         o_mode       <= 1'b0;
         o_up         <= 1'b0;
         o_down       <= 1'b0;
         o_sensor_req <= 1'b0;
         o_set_valid  <= 1'b0;
         o_cmd_err    <= 1'b0;
         o_set_hour   <= '0;
         o_set_min    <= '0;
         o_set_sec    <= '0;
      end else begin
         o_run_stop   <= 1'b0;
         o_clear      <= 1'b0;
         o_mode       <= 1'b0;
         o_up         <= 1'b0;
         o_down       <= 1'b0;
         o_sensor_req <= 1'b0;
         o_set_valid  <= 1'b0;
         o_cmd_err    <= 1'b0;

         if (!rx_empty) begin
            // An arriving byte always takes priority over an expiring timeout
            cnt <= '0;
            unique case (state)
               ST_IDLE: begin
                  unique case (byte_uc)
                     CH_R: o_run_stop   <= 1'b1;
                     CH_C: o_clear      <= 1'b1;
                     CH_M: o_mode       <= 1'b1;
                     CH_U: o_up         <= 1'b1;
                     CH_D: o_down       <= 1'b1;
                     CH_S: o_sensor_req <= 1'b1;
                     CH_T: begin
                        state <= ST_DIG0;
                        for (int unsigned i = 0; i < 6; i++) dig[i] <= '0;
                     end
                     CH_CR, CH_LF, CH_SP: ;
                     default: o_cmd_err <= 1'b1;
                  endcase
               end
               ST_DIG0, ST_DIG1, ST_DIG2, ST_DIG3, ST_DIG4, ST_DIG5: begin
                  if (is_digit) begin
                     // '0'..'9' are 0x30..0x39, so the low nibble is the digit
                     dig[dig_idx] <= rx_fifo_data[3:0];
                     state        <= state_nxt;
                  end else begin
                     o_cmd_err <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               ST_TERM: begin
                  if (is_eol && hour_ok && min_ok && sec_ok) begin
                     o_set_hour  <= hour_val;
                     o_set_min   <= min_val;
                     o_set_sec   <= sec_val;
                     o_set_valid <= 1'b1;
                  end else begin
                     o_cmd_err <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE) begin
            if (tmo) begin
               o_cmd_err <= 1'b1;
               state     <= ST_IDLE;
               cnt       <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised and directed bench for uart_cmd_decoder against a byte-stream reference model.
module tb_uart_cmd_decoder;

   localparam int unsigned TMO = 100;

   localparam logic [7:0] EV_RUN   = 8'h80;
   localparam logic [7:0] EV_CLR   = 8'h40;
   localparam logic [7:0] EV_MODE  = 8'h20;
   localparam logic [7:0] EV_UP    = 8'h10;
   localparam logic [7:0] EV_DOWN  = 8'h08;
   localparam logic [7:0] EV_SENS  = 8'h04;
   localparam logic [7:0] EV_VALID = 8'h02;
   localparam logic [7:0] EV_ERR   = 8'h01;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_empty = 1'b1;
   logic [7:0] rx_fifo_data = 8'h00;
   logic       pop;
   logic       o_run_stop, o_clear, o_mode, o_up, o_down, o_sensor_req;
   logic       o_set_valid, o_cmd_err;
   logic [4:0] o_set_hour;
   logic [5:0] o_set_min;
   logic [5:0] o_set_sec;
   logic [7:0] pulses;

   uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_fifo_data(rx_fifo_data), .pop(pop),
      .o_run_stop(o_run_stop), .o_clear(o_clear), .o_mode(o_mode), .o_up(o_up),
      .o_down(o_down), .o_sensor_req(o_sensor_req), .o_set_valid(o_set_valid),
      .o_set_hour(o_set_hour), .o_set_min(o_set_min), .o_set_sec(o_set_sec),
      .o_cmd_err(o_cmd_err)
   );

   always #5 clk = ~clk;

   assign pulses = {o_run_stop, o_clear, o_mode, o_up, o_down, o_sensor_req, o_set_valid, o_cmd_err};

   typedef struct {
      int unsigned cyc;
      logic [7:0]  vec;
   } ev_t;

   int unsigned cyc = 0;
   int unsigned multi_hot = 0;
   int unsigned last_edge = 0;
   int unsigned n_assert = 0;
   int unsigned n_fail = 0;
   ev_t         got[$];
   ev_t         exp_q[$];
   logic [7:0]  stim[$];

   // Reference model: interpretation of the byte stream, frame digits and accepted time
   int m_pos = -1;
   int m_dig[6];
   int m_h = 0, m_m = 0, m_s = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pulses !== 8'h00) got.push_back('{cyc, pulses});
      if ($countones(pulses) > 1) multi_hot++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] model_byte(input logic [7:0] b);
      logic [7:0] u;
      int h, m, s;
      u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
      if (m_pos < 0) begin
         case (u)
            "R": return EV_RUN;
            "C": return EV_CLR;
            "M": return EV_MODE;
            "U": return EV_UP;
            "D": return EV_DOWN;
            "S": return EV_SENS;
            "T": begin m_pos = 0; return 8'h00; end
            8'h0D, 8'h0A, 8'h20: return 8'h00;
            default: return EV_ERR;
         endcase
      end
      if (m_pos < 6) begin
         if (b >= 8'h30 && b <= 8'h39) begin
            m_dig[m_pos] = int'(b) - 48;
            m_pos++;
            return 8'h00;
         end
         m_pos = -1;
         return EV_ERR;
      end
      m_pos = -1;
      if (b != 8'h0D && b != 8'h0A) return EV_ERR;
      h = m_dig[0] * 10 + m_dig[1];
      m = m_dig[2] * 10 + m_dig[3];
      s = m_dig[4] * 10 + m_dig[5];
      if (h > 23 || m > 59 || s > 59) return EV_ERR;
      m_h = h; m_m = m; m_s = s;
      return EV_VALID;
   endfunction

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
   endtask

   task automatic send_byte(input logic [7:0] b, output int unsigned edge_cyc);
      @(negedge clk);
      rx_fifo_data = b;
      rx_empty     = 1'b0;
      @(posedge clk);
      #1;
      edge_cyc = cyc;
      rx_empty = 1'b1;
   endtask

   task automatic play(input int unsigned gap_max);
      int unsigned e;
      logic [7:0]  v;
      foreach (stim[i]) begin
         repeat ($urandom_range(gap_max, 0)) @(posedge clk);
         send_byte(stim[i], e);
         v = model_byte(stim[i]);
         if (v != 8'h00) exp_q.push_back('{e, v});
         last_edge = e;
      end
      stim.delete();
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_assert++;
      if ({pulses, o_set_hour, o_set_min, o_set_sec, pop} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {pulses, o_set_hour, o_set_min, o_set_sec, pop});
      end
      rst = 1'b0;
      m_pos = -1; m_h = 0; m_m = 0; m_s = 0;
      settle();
      n_assert++;
      if (got.size() != 0) begin
         n_fail++;
         $display("FAIL reset_idle_quiet: got %0d pulses required 0", got.size());
      end
   endtask

   task automatic test_back_to_back();
      got.delete(); exp_q.delete();
      push_str("RcM");
      play(0);
      settle();
      n_assert++;
      if (pop !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_pop_idle: got %b required 0", pop);
      end
      n_assert++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d required %0d", got.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            n_assert++;
            if (got[i].cyc !== exp_q[i].cyc || got[i].vec !== exp_q[i].vec) begin
               n_fail++;
               $display("FAIL b2b_ev%0d: got cyc %0d vec %h required cyc %0d vec %h",
                        i, got[i].cyc, got[i].vec, exp_q[i].cyc, exp_q[i].vec);
            end
         end
      end
      @(negedge clk);
      rx_fifo_data = 8'h20;
      rx_empty     = 1'b0;
      #1;
      n_assert++;
      if (pop !== 1'b1) begin
         n_fail++;
         $display("FAIL pop_when_ready: got %b required 1", pop);
      end
      @(posedge clk);
      #1;
      rx_empty = 1'b1;
      void'(model_byte(8'h20));
      #1;
      n_assert++;
      if (pop !== 1'b0) begin
         n_fail++;
         $display("FAIL pop_falls: got %b required 0", pop);
      end
   endtask

   task automatic test_set_time();
      got.delete(); exp_q.delete();
      push_str("T123456\r");
      play(2);
      settle();
      n_assert++;
      if (got.size() != 1 || got[0].vec !== EV_VALID || got[0].cyc !== last_edge) begin
         n_fail++;
         $display("FAIL set_valid_pulse: got %0d events required one valid at cyc %0d",
                  got.size(), last_edge);
      end
      n_assert++;
      if (o_set_hour !== 5'd12 || o_set_min !== 6'd34 || o_set_sec !== 6'd56) begin
         n_fail++;
         $display("FAIL set_values: got %0d:%0d:%0d required 12:34:56",
                  o_set_hour, o_set_min, o_set_sec);
      end
      got.delete(); exp_q.delete();
      push_str("T246000\n");
      play(1);
      settle();
      n_assert++;
      if (got.size() != 1 || got[0].vec !== EV_ERR || got[0].cyc !== last_edge) begin
         n_fail++;
         $display("FAIL range_err_pulse: got %0d events required one err at cyc %0d",
                  got.size(), last_edge);
      end
      n_assert++;
      if (o_set_hour !== 5'd12 || o_set_min !== 6'd34 || o_set_sec !== 6'd56) begin
         n_fail++;
         $display("FAIL range_hold: got %0d:%0d:%0d required 12:34:56",
                  o_set_hour, o_set_min, o_set_sec);
      end
   endtask

   task automatic test_bad_digit();
      got.delete(); exp_q.delete();
      push_str("T12aU");
      play(0);
      settle();
      n_assert++;
      if (got.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL bad_digit_count: got %0d required %0d", got.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            n_assert++;
            if (got[i].cyc !== exp_q[i].cyc || got[i].vec !== exp_q[i].vec) begin
               n_fail++;
               $display("FAIL bad_digit_ev%0d: got cyc %0d vec %h required cyc %0d vec %h",
                        i, got[i].cyc, got[i].vec, exp_q[i].cyc, exp_q[i].vec);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int unsigned last;
      got.delete(); exp_q.delete();
      push_str("T12");
      play(0);
      last = last_edge;
      repeat (TMO + 5) @(posedge clk);
      settle();
      m_pos = -1;
      n_assert++;
      if (got.size() != 1 || got[0].cyc !== last + TMO || got[0].vec !== EV_ERR) begin
         n_fail++;
         $display("FAIL timeout_edge: got %0d events (first cyc %0d) required one err at cyc %0d",
                  got.size(), (got.size() > 0) ? got[0].cyc : 0, last + TMO);
      end
      got.delete();
      push_str("T12");
      play(0);
      repeat (TMO - 1) @(posedge clk);
      push_str("3");
      play(0);
      settle();
      n_assert++;
      if (got.size() != 0) begin
         n_fail++;
         $display("FAIL timeout_byte_wins: got %0d events required 0", got.size());
      end
      last = last_edge;
      repeat (TMO + 5) @(posedge clk);
      settle();
      m_pos = -1;
      n_assert++;
      if (got.size() != 1 || got[0].cyc !== last + TMO || got[0].vec !== EV_ERR) begin
         n_fail++;
         $display("FAIL timeout_restart: got %0d events required one err at cyc %0d",
                  got.size(), last + TMO);
      end
   endtask

   task automatic test_reset_midframe();
      got.delete(); exp_q.delete();
      push_str("T123");
      play(0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_assert++;
      if ({pulses, o_set_hour, o_set_min, o_set_sec, pop} !== 25'd0) begin
         n_fail++;
         $display("FAIL midframe_reset_outputs: got %h required 0",
                  {pulses, o_set_hour, o_set_min, o_set_sec, pop});
      end
      m_pos = -1; m_h = 0; m_m = 0; m_s = 0;
      @(negedge clk);
      rst = 1'b0;
      push_str("56\r");
      play(0);
      settle();
      n_assert++;
      if (got.size() != exp_q.size() || exp_q.size() != 2) begin
         n_fail++;
         $display("FAIL midframe_count: got %0d required 2", got.size());
      end else begin
         foreach (exp_q[i]) begin
            n_assert++;
            if (got[i].cyc !== exp_q[i].cyc || got[i].vec !== exp_q[i].vec) begin
               n_fail++;
               $display("FAIL midframe_ev%0d: got cyc %0d vec %h required cyc %0d vec %h",
                        i, got[i].cyc, got[i].vec, exp_q[i].cyc, exp_q[i].vec);
            end
         end
      end
   endtask

   task automatic test_random();
      string cmds = "RCMUDSrcmuds";
      int    h, m, s, k;
      for (int round = 0; round < 4; round++) begin
         got.delete(); exp_q.delete();
         for (int item = 0; item < 30; item++) begin
            case ($urandom_range(5, 0))
               0: stim.push_back(cmds[$urandom_range(11, 0)]);
               1, 2: begin
                  if ($urandom_range(1, 0) == 1) begin
                     h = $urandom_range(23, 0); m = $urandom_range(59, 0); s = $urandom_range(59, 0);
                  end else begin
                     h = $urandom_range(99, 0); m = $urandom_range(99, 0); s = $urandom_range(99, 0);
                  end
                  stim.push_back(($urandom_range(1, 0) == 1) ? 8'h54 : 8'h74);
                  stim.push_back(8'(48 + h / 10)); stim.push_back(8'(48 + h % 10));
                  stim.push_back(8'(48 + m / 10)); stim.push_back(8'(48 + m % 10));
                  stim.push_back(8'(48 + s / 10)); stim.push_back(8'(48 + s % 10));
                  case ($urandom_range(3, 0))
                     0: stim.push_back(8'h78);
                     1: stim.push_back(8'h0A);
                     default: stim.push_back(8'h0D);
                  endcase
               end
               3: begin
                  stim.push_back(8'h54);
                  k = $urandom_range(5, 0);
                  for (int j = 0; j < k; j++) stim.push_back(8'(48 + $urandom_range(9, 0)));
                  stim.push_back(8'(97 + $urandom_range(25, 0)));
               end
               4: stim.push_back(8'($urandom_range(255, 0)));
               default: stim.push_back(8'h20);
            endcase
         end
         stim.push_back(8'h0A);
         play(3);
         settle();
         n_assert++;
         if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d required %0d", round, got.size(), exp_q.size());
         end else begin
            foreach (exp_q[i]) begin
               n_assert++;
               if (got[i].cyc !== exp_q[i].cyc || got[i].vec !== exp_q[i].vec) begin
                  n_fail++;
                  $display("FAIL rand%0d_ev%0d: got cyc %0d vec %h required cyc %0d vec %h",
                           round, i, got[i].cyc, got[i].vec, exp_q[i].cyc, exp_q[i].vec);
               end
            end
         end
         n_assert++;
         if (int'(o_set_hour) != m_h || int'(o_set_min) != m_m || int'(o_set_sec) != m_s) begin
            n_fail++;
            $display("FAIL rand%0d_time: got %0d:%0d:%0d required %0d:%0d:%0d", round,
                     o_set_hour, o_set_min, o_set_sec, m_h, m_m, m_s);
         end
      end
      n_assert++;
      if (multi_hot != 0) begin
         n_fail++;
         $display("FAIL one_hot_pulses: got %0d multi-pulse cycles required 0", multi_hot);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_set_time();
      test_bad_digit();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
